dmem_arbiter: RTL

//  Shares the single-port data RAM (ram_data) among NUM_CORES core load/store units.
//  One access is in flight at a time. Requesters are granted round-robin.
//  The block latches the winning request, drives ram_data ADDBUS/DATAIN/WR/RD,

---
 rtl/dmem_arbiter_pkg.sv | 25 ++
 rtl/dmem_arbiter_rr_pick.sv | 26 ++
 rtl/dmem_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter: FSM states, default bus widths, pointer helper.
// Latency: none (definitions only).
// Backpressure: not applicable.
package dmem_arbiter_pkg;

    // Arbiter FSM states; encodings are fixed so debug views stay stable.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Bus widths shared with ram_data ADDBUS / DATAIN / DATAOUT.
    localparam int ADDR_W_DEF    = 16;
    localparam int DATA_W_DEF    = 16;
    localparam int NUM_CORES_DEF = 4;
    localparam int RD_LAT_DEF    = 1;

    // Round-robin successor of requester id among n requesters.
    function automatic int rr_next(input int id, input int n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching ptr, ptr+1, ... mod N.
// Latency: zero cycles (pure combinational).
// Backpressure: none; caller decides when the pick is consumed.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] win_id
);

    // Scan from the farthest offset down to ptr so the nearest requester overrides.
    always_comb begin
        any    = 1'b0;
        win_id = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                any    = 1'b1;
                win_id = IDX_W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port ram_data among NUM_CORES load/store units, one access in flight, round-robin.
// Latency from IDLE sample at t: write ack at t+2, read ack at t+2+RD_LAT; next grant one cycle after ack.
// Backpressure: requesters hold req and operands until their one-cycle ack; RAM never stalls.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RD_LAT    = RD_LAT_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_wr,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_ack,
    output logic [DATA_W-1:0]           core_rdata,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_wr,
    output logic                        mem_rd,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int IDX_W = $clog2(NUM_CORES);
    localparam int LAT_W = $clog2(RD_LAT + 1);

    state_t                state_q,      state_d;
    logic [IDX_W-1:0]      ptr_q,        ptr_d;
    logic [IDX_W-1:0]      win_id_q,     win_id_d;
    logic                  wr_q,         wr_d;
    logic [LAT_W-1:0]      lat_cnt_q,    lat_cnt_d;
    logic [ADDR_W-1:0]     mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q,  mem_wdata_d;
    logic                  mem_wr_q,     mem_wr_d;
    logic                  mem_rd_q,     mem_rd_d;
    logic [NUM_CORES-1:0]  core_ack_q,   core_ack_d;
    logic [DATA_W-1:0]     core_rdata_q, core_rdata_d;

    logic                  pick_any;
    logic [IDX_W-1:0]      pick_id;

    rr_pick #(
        .N     (NUM_CORES),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (core_req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .win_id (pick_id)
    );

    // Next-state and registered-output logic; outputs are computed one cycle ahead so they are flop-driven.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        win_id_d     = win_id_q;
        wr_d         = wr_q;
        lat_cnt_d    = lat_cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wr_d     = 1'b0;
        mem_rd_d     = 1'b0;
        core_ack_d   = '0;
        core_rdata_d = core_rdata_q;

        case (state_q)
            ST_IDLE: begin
                // The winner's operands go straight into the RAM-facing registers, which double as the latch.
                if (pick_any) begin
                    win_id_d    = pick_id;
                    wr_d        = core_wr[pick_id];
                    mem_addr_d  = core_addr[int'(pick_id)*ADDR_W +: ADDR_W];
                    mem_wdata_d = core_wdata[int'(pick_id)*DATA_W +: DATA_W];
                    mem_wr_d    = core_wr[pick_id];
                    mem_rd_d    = ~core_wr[pick_id];
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (wr_q) begin
                    core_ack_d[win_id_q] = 1'b1;
                    state_d              = ST_RESP;
                end else begin
                    lat_cnt_d = LAT_W'(RD_LAT);
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                lat_cnt_d = lat_cnt_q - 1'b1;
                // DATAOUT is valid on the last WAIT cycle; capture it alongside the ack.
                if (lat_cnt_q == LAT_W'(1)) begin
                    core_rdata_d         = mem_rdata;
                    core_ack_d[win_id_q] = 1'b1;
                    state_d              = ST_RESP;
                end
            end
            ST_RESP: begin
                ptr_d   = IDX_W'(rr_next(int'(win_id_q), NUM_CORES));
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            win_id_q     <= '0;
            wr_q         <= 1'b0;
            lat_cnt_q    <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wr_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
            core_ack_q   <= '0;
            core_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            win_id_q     <= win_id_d;
            wr_q         <= wr_d;
            lat_cnt_q    <= lat_cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wr_q     <= mem_wr_d;
            mem_rd_q     <= mem_rd_d;
            core_ack_q   <= core_ack_d;
            core_rdata_q <= core_rdata_d;
        end
    end

    assign core_ack   = core_ack_q;
    assign core_rdata = core_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wr     = mem_wr_q;
    assign mem_rd     = mem_rd_q;

endmodule
